prom_sweep_ctrl: RTL

- Sequential driver and capture stage wrapped around the combinational PROM function block.
- Upstream role: on request, generates the enable and steps the address through every PROM address.
- Downstream role: samples each function output and assembles the complete truth table into one packed register.
- Used for self-check and boot-time table readout; the PROM stays purely combinational.

---
 rtl/prom_sweep_pkg.sv | 16 +
 rtl/prom_sweep_ctrl_if.sv | 12 +
 rtl/prom_sweep_capture.sv | 32 +++
 rtl/prom_sweep_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/prom_sweep_pkg.sv
// Shared types and constants for the PROM sweep controller and its capture bank.
package prom_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DWELL_W = 8;

  function automatic int num_addr(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/prom_sweep_ctrl_if.sv
// PROM drive/sense bus: the controller (master) drives enable and address, the PROM (slave) returns its function outputs.
interface prom_sweep_ctrl_if #(
  parameter int AW = 2,
  parameter int FW = 2
);
  logic          prom_en;
  logic [AW-1:0] prom_addr;
  logic [FW-1:0] prom_f;

  modport master (output prom_en, output prom_addr, input prom_f);
  modport slave  (input prom_en, input prom_addr, output prom_f);
endinterface

// File: rtl/prom_sweep_capture.sv
// Truth-table register bank: one FW-bit slot per PROM address, written at the selected slot when i_we is high.
// Latency: slot visible on o_table the cycle after the write; no backpressure, i_clr has priority over i_we.
module prom_sweep_capture
  import prom_sweep_pkg::*;
#(
  parameter int AW = 2,
  parameter int FW = 2
) (
  input  logic                       i_clk,
  input  logic                       i_clr,
  input  logic                       i_we,
  input  logic [AW-1:0]              i_slot,
  input  logic [FW-1:0]              i_dat,
  output logic [num_addr(AW)*FW-1:0] o_table
);
  localparam int N = num_addr(AW);

  for (genvar k = 0; k < N; k++) begin : g_slot
    logic [FW-1:0] r_dat;

    always_ff @(posedge i_clk) begin
      if (i_clr) begin
        r_dat <= '0;
      end else if (i_we && (i_slot == AW'(k))) begin
        r_dat <= i_dat;
      end
    end

    assign o_table[k*FW +: FW] = r_dat;
  end

endmodule

// File: rtl/prom_sweep_ctrl.sv
// Steps the PROM through all N addresses (each held DWELL cycles) and assembles the sampled truth table; PROM_SWEEP_CHECK_EN adds a golden-table mismatch flag.
// Latency: done pulses N*DWELL+1 cycles after an accepted start; no backpressure, start is ignored (not queued) outside IDLE.
module prom_sweep_ctrl
  import prom_sweep_pkg::*;
#(
  parameter int AW    = 2,
  parameter int FW    = 2,
  parameter int DWELL = 2
`ifdef PROM_SWEEP_CHECK_EN
  ,
  parameter logic [num_addr(AW)*FW-1:0] EXPECTED = '0
`endif
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  prom_sweep_ctrl_if.master          io_prom,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [num_addr(AW)*FW-1:0] o_table_out,
  output logic                       o_table_valid
`ifdef PROM_SWEEP_CHECK_EN
  ,
  output logic                       o_mismatch
`endif
);
  localparam int                 N          = num_addr(AW);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [AW-1:0]      ADDR_LAST  = AW'(N - 1);

  state_t             r_state, w_state_nxt;
  logic [AW-1:0]      r_addr, w_addr_nxt;
  logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
  logic               r_table_valid, w_table_valid_nxt;
  logic               w_capture;
  logic               w_prom_en;
  logic               w_busy;
  logic               w_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_dwell       <= '0;
      r_table_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_addr        <= w_addr_nxt;
      r_dwell       <= w_dwell_nxt;
      r_table_valid <= w_table_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_addr_nxt        = r_addr;
    w_dwell_nxt       = r_dwell;
    w_table_valid_nxt = r_table_valid;
    w_capture         = 1'b0;
    w_prom_en         = 1'b0;
    w_busy            = 1'b0;
    w_done            = 1'b0;

    case (r_state)
      IDLE: begin
        w_addr_nxt  = '0;
        w_dwell_nxt = '0;
        if (i_start) begin
          w_state_nxt       = RUN;
          w_table_valid_nxt = 1'b0;
        end
      end
      RUN: begin
        w_prom_en = 1'b1;
        w_busy    = 1'b1;
        // Sample only once the address has been stable for the full dwell.
        if (r_dwell == DWELL_LAST) begin
          w_capture   = 1'b1;
          w_dwell_nxt = '0;
          if (r_addr == ADDR_LAST) begin
            w_state_nxt       = FIN;
            w_table_valid_nxt = 1'b1;
          end else begin
            w_addr_nxt = r_addr + AW'(1);
          end
        end else begin
          w_dwell_nxt = r_dwell + DWELL_W'(1);
        end
      end
      FIN: begin
        w_done      = 1'b1;
        w_addr_nxt  = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  prom_sweep_capture #(
    .AW (AW),
    .FW (FW)
  ) u_capture (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_we    (w_capture),
    .i_slot  (r_addr),
    .i_dat   (io_prom.prom_f),
    .o_table (o_table_out)
  );

`ifdef PROM_SWEEP_CHECK_EN
  logic r_mismatch;

  // The table is complete during FIN, so the compare is latched on the way out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mismatch <= 1'b0;
    end else if (r_state == IDLE && i_start) begin
      r_mismatch <= 1'b0;
    end else if (r_state == FIN) begin
      r_mismatch <= (o_table_out != EXPECTED);
    end
  end

  assign o_mismatch = r_mismatch;
`endif

  assign io_prom.prom_en   = w_prom_en;
  assign io_prom.prom_addr = r_addr;
  assign o_busy            = w_busy;
  assign o_done            = w_done;
  assign o_table_valid     = r_table_valid;

endmodule
